// File: rtl/ivector_pkg.sv
// Shared types and the say/heard pattern rule for the IVector requester.
package ivector_pkg;
    localparam int IVEC_W = 192;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [IVEC_W-1:0] meth;
        logic [IVEC_W-1:0] v;
    } ivec_pair_t;

    // meth wraps modulo 2^IVEC_W; v is always its complement
    function automatic ivec_pair_t ivec_pattern(input logic [IVEC_W-1:0] seed,
                                                input logic [IVEC_W-1:0] idx);
        ivec_pair_t p;
        p.meth = seed + idx;
        p.v    = ~p.meth;
        return p;
    endfunction
endpackage

// File: rtl/ivector_pattern.sv
// Combinational pattern generator: (seed, idx) -> (meth, v).
module ivector_pattern
    import ivector_pkg::*;
#(
    parameter int IDX_W = 16
) (
    input  logic [IVEC_W-1:0] i_seed,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [IVEC_W-1:0] o_meth,
    output logic [IVEC_W-1:0] o_v
);
    ivec_pair_t w_pair;

    assign w_pair = ivec_pattern(i_seed, IVEC_W'(i_idx));
    assign o_meth = w_pair.meth;
    assign o_v    = w_pair.v;
endmodule

// File: rtl/ivector_requester.sv
// Issues a burst of say(meth, v) requests and scoreboards the in-order heard(meth, v) replies.
module ivector_requester
    import ivector_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start__ENA,
    input  logic [CNT_W-1:0]  start_count,
    input  logic [IVEC_W-1:0] start_seed,
    output logic              start__RDY,
    output logic              say__ENA,
    output logic [IVEC_W-1:0] say_meth,
    output logic [IVEC_W-1:0] say_v,
    input  logic              say__RDY,
    input  logic              heard__ENA,
    input  logic [IVEC_W-1:0] heard_meth,
    input  logic [IVEC_W-1:0] heard_v,
    output logic              heard__RDY,
    input  logic              done__ENA,
    output logic              done__RDY,
    output logic [CNT_W-1:0]  done_errors,
    output logic [CNT_W-1:0]  done_first_bad,
    input  logic              rule_enable,
    output logic              rule_ready
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    state_t            r_state;
    logic [IVEC_W-1:0] r_seed;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_send_idx;
    logic [CNT_W-1:0]  r_recv_idx;
    logic [CNT_W-1:0]  r_errors;
    logic [CNT_W-1:0]  r_first_bad;
    logic [OUT_W-1:0]  r_out;

    logic              w_issue_rdy;
    logic              w_heard_acc;
    logic              w_mismatch;
    logic [CNT_W-1:0]  w_recv_nxt;
    logic [IVEC_W-1:0] w_chk_meth;
    logic [IVEC_W-1:0] w_chk_v;

    ivector_pattern #(.IDX_W(CNT_W)) u_issue_pat (
        .i_seed (r_seed),
        .i_idx  (r_send_idx),
        .o_meth (say_meth),
        .o_v    (say_v)
    );

    ivector_pattern #(.IDX_W(CNT_W)) u_check_pat (
        .i_seed (r_seed),
        .i_idx  (r_recv_idx),
        .o_meth (w_chk_meth),
        .o_v    (w_chk_v)
    );

    assign w_issue_rdy    = (r_state == RUN) && (r_send_idx < r_count) && (r_out < OUT_MAX) && say__RDY;
    assign say__ENA       = rule_enable & w_issue_rdy;
    assign rule_ready     = w_issue_rdy;
    // heard is gated by the registered outstanding count, so a same-cycle say never qualifies it
    assign heard__RDY     = (r_state == RUN) && (r_out != '0);
    assign w_heard_acc    = heard__ENA & heard__RDY;
    assign w_mismatch     = (heard_meth != w_chk_meth) || (heard_v != w_chk_v);
    assign w_recv_nxt     = r_recv_idx + CNT_W'(1);
    assign start__RDY     = (r_state == IDLE);
    assign done__RDY      = (r_state == DONE);
    assign done_errors    = r_errors;
    assign done_first_bad = r_first_bad;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_send_idx  <= '0;
            r_recv_idx  <= '0;
            r_errors    <= '0;
            r_first_bad <= '1;
            r_out       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start__ENA) begin
                        r_seed      <= start_seed;
                        r_count     <= start_count;
                        r_send_idx  <= '0;
                        r_recv_idx  <= '0;
                        r_out       <= '0;
                        r_errors    <= '0;
                        r_first_bad <= '1;
                        r_state     <= (start_count == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (say__ENA) begin
                        r_send_idx <= r_send_idx + CNT_W'(1);
                    end
                    if (w_heard_acc) begin
                        if (w_mismatch) begin
                            if (r_errors != '1) begin
                                r_errors <= r_errors + CNT_W'(1);
                            end
                            if (r_first_bad == '1) begin
                                r_first_bad <= r_recv_idx;
                            end
                        end
                        r_recv_idx <= w_recv_nxt;
                        if (w_recv_nxt == r_count) begin
                            r_state <= DONE;
                        end
                    end
                    case ({say__ENA, w_heard_acc})
                        2'b10:   r_out <= r_out + OUT_W'(1);
                        2'b01:   r_out <= r_out - OUT_W'(1);
                        default: r_out <= r_out;
                    endcase
                end
                DONE: begin
                    if (done__ENA) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ivector_requester.sv
// Directed bench for ivector_requester with an in-bench echo responder.
module tb_ivector_requester;
    localparam int W = 192;
    localparam int CNT_W = 16;

    logic             CLK;
    logic             nRST;
    logic             start__ENA;
    logic [CNT_W-1:0] start_count;
    logic [W-1:0]     start_seed;
    logic             start__RDY;
    logic             say__ENA;
    logic [W-1:0]     say_meth;
    logic [W-1:0]     say_v;
    logic             say__RDY;
    logic             heard__ENA;
    logic [W-1:0]     heard_meth;
    logic [W-1:0]     heard_v;
    logic             heard__RDY;
    logic             done__ENA;
    logic             done__RDY;
    logic [CNT_W-1:0] done_errors;
    logic [CNT_W-1:0] done_first_bad;
    logic             rule_enable;
    logic             rule_ready;

    ivector_requester #(.MAX_OUTSTANDING(4), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .start__ENA(start__ENA), .start_count(start_count), .start_seed(start_seed),
        .start__RDY(start__RDY),
        .say__ENA(say__ENA), .say_meth(say_meth), .say_v(say_v), .say__RDY(say__RDY),
        .heard__ENA(heard__ENA), .heard_meth(heard_meth), .heard_v(heard_v),
        .heard__RDY(heard__RDY),
        .done__ENA(done__ENA), .done__RDY(done__RDY),
        .done_errors(done_errors), .done_first_bad(done_first_bad),
        .rule_enable(rule_enable), .rule_ready(rule_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int hcnt = 0;
    int n_says = 0;
    int bad_m = -1;
    int bad_v = -1;
    bit echo_en = 1'b0;
    logic [W-1:0] q_meth[$];
    logic [W-1:0] q_v[$];
    int           q_t[$];
    logic [W-1:0] s;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes taken at this edge, then present the next echo
    task automatic tick();
        #1;
        if (say__ENA) begin
            q_meth.push_back(say_meth);
            q_v.push_back(say_v);
            q_t.push_back(cyc);
            n_says++;
        end
        if (heard__ENA && heard__RDY) begin
            void'(q_meth.pop_front());
            void'(q_v.pop_front());
            void'(q_t.pop_front());
            hcnt++;
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (echo_en) begin
            heard__ENA = 1'b0;
            if (q_t.size() > 0 && (cyc - q_t[0]) >= 2) begin
                heard__ENA = 1'b1;
                heard_meth = q_meth[0] ^ ((hcnt == bad_m) ? (192'd1 << 7) : 192'd0);
                heard_v    = q_v[0] ^ ((hcnt == bad_v) ? 192'd1 : 192'd0);
            end
        end
        #1;
    endtask

    task automatic start_burst(input logic [CNT_W-1:0] cnt, input logic [W-1:0] seed);
        q_meth.delete();
        q_v.delete();
        q_t.delete();
        hcnt = 0;
        n_says = 0;
        start__ENA = 1'b1;
        start_count = cnt;
        start_seed = seed;
        tick();
        start__ENA = 1'b0;
    endtask

    task automatic run_until_heard(input int n, input int budget);
        for (int i = 0; i < budget && hcnt < n; i++) tick();
    endtask

    task automatic finish_done();
        done__ENA = 1'b1;
        tick();
        done__ENA = 1'b0;
    endtask

    initial begin
        nRST = 1'b0; start__ENA = 1'b0; start_count = '0; start_seed = '0;
        say__RDY = 1'b1; heard__ENA = 1'b0; heard_meth = '0; heard_v = '0;
        done__ENA = 1'b0; rule_enable = 1'b1;
        tick(); tick();
        nRST = 1'b1;
        check("rst_start_rdy", start__RDY, 1'b1);
        check("rst_say_ena", say__ENA, 1'b0);
        check("rst_heard_rdy", heard__RDY, 1'b0);
        check("rst_done_rdy", done__RDY, 1'b0);
        check("rst_errors", done_errors, 16'h0000);
        check("rst_first_bad", done_first_bad, 16'hFFFF);

        // Basic burst
        echo_en = 1'b1;
        start_burst(16'd3, 192'd0);
        check("b_say0_ena", say__ENA, 1'b1);
        check("b_say0_meth", say_meth, 192'd0);
        check("b_say0_v", say_v, ~192'd0);
        tick();
        check("b_say1_meth", say_meth, 192'd1);
        check("b_say1_v", say_v, ~192'd1);
        tick();
        check("b_say2_meth", say_meth, 192'd2);
        check("b_say2_v", say_v, ~192'd2);
        run_until_heard(3, 20);
        check("b_heard_count", hcnt, 3);
        check("b_done_next_cycle", done__RDY, 1'b1);
        check("b_says", n_says, 3);
        check("b_errors", done_errors, 16'd0);
        check("b_first_bad", done_first_bad, 16'hFFFF);
        finish_done();
        check("b_back_idle", start__RDY, 1'b1);

        // Flow control and simultaneous say/heard
        echo_en = 1'b0;
        heard__ENA = 1'b0;
        start_burst(16'd10, 192'd100);
        repeat (8) tick();
        check("fc_says_capped", n_says, 4);
        check("fc_say_low", say__ENA, 1'b0);
        check("fc_heard_rdy", heard__RDY, 1'b1);
        heard__ENA = 1'b1; heard_meth = 192'd100; heard_v = ~192'd100;
        tick();
        heard__ENA = 1'b0;
        check("fc_one_more_ena", say__ENA, 1'b1);
        check("fc_one_more_meth", say_meth, 192'd104);
        tick();
        check("fc_capped_again", say__ENA, 1'b0);
        check("fc_says5", n_says, 5);
        heard__ENA = 1'b1; heard_meth = 192'd101; heard_v = ~192'd101;
        tick();
        heard_meth = 192'd102; heard_v = ~192'd102;
        check("sim_say_ready", say__ENA, 1'b1);
        tick();
        heard__ENA = 1'b0;
        check("sim_out_not_inc", say__ENA, 1'b1);
        check("sim_next_meth", say_meth, 192'd106);
        tick();
        check("sim_out_not_dec", say__ENA, 1'b0);
        echo_en = 1'b1;
        run_until_heard(10, 60);
        check("fc_heard_count", hcnt, 10);
        check("fc_done", done__RDY, 1'b1);
        check("fc_errors", done_errors, 16'd0);
        finish_done();

        // Mismatch scoring
        bad_m = 2; bad_v = 4;
        start_burst(16'd5, 192'd7);
        run_until_heard(3, 30);
        check("mm_errors_mid", done_errors, 16'd1);
        check("mm_first_bad_mid", done_first_bad, 16'd2);
        run_until_heard(5, 30);
        check("mm_done", done__RDY, 1'b1);
        check("mm_errors", done_errors, 16'd2);
        check("mm_first_bad", done_first_bad, 16'd2);
        finish_done();
        check("mm_hold_errors", done_errors, 16'd2);
        check("mm_hold_first_bad", done_first_bad, 16'd2);
        bad_m = -1; bad_v = -1;

        // Pattern wrap
        s = '1;
        s = s - 192'd1;
        start_burst(16'd3, s);
        check("wr_meth0", say_meth, s);
        tick();
        s = '1;
        check("wr_meth1", say_meth, s);
        tick();
        check("wr_meth2", say_meth, 192'd0);
        check("wr_v2", say_v, s);
        run_until_heard(3, 20);
        check("wr_done", done__RDY, 1'b1);
        check("wr_errors", done_errors, 16'd0);
        finish_done();

        // Empty burst
        start_burst(16'd0, 192'd55);
        check("z_done", done__RDY, 1'b1);
        check("z_no_say", say__ENA, 1'b0);
        check("z_heard_rdy", heard__RDY, 1'b0);
        tick();
        check("z_says", n_says, 0);
        finish_done();

        // Illegal heard with nothing outstanding, ignored start, rule gating
        echo_en = 1'b0;
        rule_enable = 1'b0;
        start_burst(16'd2, 192'd5);
        check("il_rule_ready", rule_ready, 1'b1);
        check("il_say_gated", say__ENA, 1'b0);
        check("il_heard_rdy", heard__RDY, 1'b0);
        heard__ENA = 1'b1; heard_meth = 192'd5; heard_v = ~192'd5;
        start__ENA = 1'b1; start_count = 16'd0;
        tick();
        heard__ENA = 1'b0; start__ENA = 1'b0;
        check("il_start_ignored", done__RDY, 1'b0);
        check("il_still_run", start__RDY, 1'b0);
        rule_enable = 1'b1;
        echo_en = 1'b1;
        run_until_heard(2, 20);
        check("il_done", done__RDY, 1'b1);
        check("il_heard_ignored", done_errors, 16'd0);
        finish_done();

        // Mid-burst reset with two says in flight
        echo_en = 1'b0;
        heard__ENA = 1'b0;
        start_burst(16'd6, 192'd50);
        tick(); tick();
        check("mr_two_out", n_says, 2);
        say__RDY = 1'b0;
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        check("mr_start_rdy", start__RDY, 1'b1);
        check("mr_say_ena", say__ENA, 1'b0);
        check("mr_heard_rdy", heard__RDY, 1'b0);
        check("mr_done_rdy", done__RDY, 1'b0);
        check("mr_errors", done_errors, 16'd0);
        check("mr_first_bad", done_first_bad, 16'hFFFF);
        say__RDY = 1'b1;
        echo_en = 1'b1;
        start_burst(16'd2, 192'd9);
        check("mr2_meth0", say_meth, 192'd9);
        run_until_heard(2, 20);
        check("mr2_done", done__RDY, 1'b1);
        check("mr2_errors", done_errors, 16'd0);
        check("mr2_first_bad", done_first_bad, 16'hFFFF);
        finish_done();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ivector_requester.md
# ivector_requester

Request-side partner of the IVector echo block: issues a burst of `say(meth, v)` requests and consumes the returning `heard(meth, v)` indications. Each returned pair is checked against the pattern that was sent, and mismatches are counted. It sits between a test or host controller and the IVector responder, which returns indications in order through its internal FIFO. It serves as traffic source and as in-order scoreboard.

## Interface
Parameters:
- MAX_OUTSTANDING, default 4: maximum number of says issued but not yet heard (range 1..15).
- CNT_W, default 16: width of the burst count and of the error counters.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset: synchronous, active-low.
- start__ENA  in  1  begins a burst; acted on only while start__RDY=1.
- start_count  in  CNT_W  number of requests in the burst.
- start_seed  in  192  pattern seed.
- start__RDY  out  1  high only in IDLE.
- say__ENA  out  1  request strobe to the responder.
- say_meth  out  192  seed + send_idx (mod 2^192).
- say_v  out  192  bitwise NOT of say_meth.
- say__RDY  in  1  responder can accept a request.
- heard__ENA  in  1  indication strobe from the responder.
- heard_meth  in  192  returned meth.
- heard_v  in  192  returned v.
- heard__RDY  out  1  block can accept an indication.
- done__ENA  in  1  acknowledges the result; acted on only while done__RDY=1.
- done__RDY  out  1  high in DONE.
- done_errors  out  CNT_W  mismatch count; saturates at all-ones.
- done_first_bad  out  CNT_W  index of the first mismatch; all-ones if there was none.
- rule_enable  in  1  bit 0 gates the internal `issue` rule.
- rule_ready  out  1  bit 0 = issue__RDY.

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - seed (192 bits).
  - count, send_idx, recv_idx, errors, first_bad (CNT_W bits each).
  - outstanding (clog2(MAX_OUTSTANDING+1) bits).
- IDLE, on start__ENA:
  - Latch seed and count.
  - Clear send_idx, recv_idx and outstanding; set errors=0 and first_bad=all-ones.
  - Go to RUN. If count==0, go directly to DONE.
- issue__RDY = (state==RUN) & (send_idx<count) & (outstanding<MAX_OUTSTANDING) & say__RDY.
- say__ENA = rule_enable[0] & issue__RDY. When it fires, send_idx increments.
- heard__RDY = (state==RUN) & (outstanding!=0).
- Accepted heard (heard__ENA & heard__RDY):
  - Compare heard_meth against seed+recv_idx, and heard_v against its complement.
  - On mismatch: errors increments (saturating). If first_bad is all-ones, it takes recv_idx.
  - recv_idx increments.
- heard__ENA while heard__RDY=0 is ignored and changes no state.
- outstanding: +1 on say only, -1 on heard only, unchanged when both fire in the same cycle.
- RUN → DONE when an accepted heard makes recv_idx equal count.
- DONE → IDLE on done__ENA. done_errors and done_first_bad hold their values until the next start.
- start__ENA outside IDLE and done__ENA outside DONE are ignored.

## Timing
- All state is updated at posedge CLK. Strobe outputs are combinational from registers and from the *__RDY/rule_enable inputs.
- Reset (nRST=0 at an edge), including in the middle of a burst:
  - state=IDLE, so start__RDY=1.
  - say__ENA=0, heard__RDY=0, done__RDY=0.
  - All counters 0; done_first_bad=all-ones.
  - Any in-flight says are abandoned.
- Latencies:
  - A start accepted in cycle t allows the first say in cycle t+1.
  - With say__RDY held high, one say per cycle until the outstanding limit is reached.
  - The last heard accepted in cycle t gives done__RDY=1 in cycle t+1.
- A heard may be accepted in the same cycle as a say. It is never accepted for a say issued in that same cycle, because outstanding is read registered.
- Pattern arithmetic is 192-bit and wraps modulo 2^192. Index counters do not wrap: count ≤ 2^CNT_W−1.

## Structure
- Shared package ivector_pkg holds:
  - State enum: IDLE, RUN, DONE.
  - IVEC_W=192.
  - The pattern function: meth = seed+idx, v = ~meth.
- One natural sub-module: ivector_pattern, purely combinational (seed, idx → meth, v). It is instantiated twice: once for issue (send_idx) and once for check (recv_idx).

## Test plan
- Basic burst: seed=0, count=3, say__RDY=1, indications echoed 2 cycles later → says carry meth 0,1,2 with v ~0,~1,~2. done__RDY rises 1 cycle after the 3rd heard; done_errors=0; done_first_bad=0xFFFF.
- Flow control: MAX_OUTSTANDING=4, count=10, heard withheld → exactly 4 says issued, then say__ENA stays low. Releasing one heard allows exactly one more say.
- Mismatch: count=5, heard #2 has meth bit 7 flipped → done_errors=1, done_first_bad=2. Corrupting v on #4 as well gives done_errors=2, done_first_bad still 2.
- Wrap and edge cases:
  - seed=2^192−2, count=3 → meth values 2^192−2, 2^192−1, 0.
  - count=0 → done__RDY in the cycle after start, and no say is issued.
- Simultaneous and illegal traffic: a say and a heard in the same cycle leave outstanding unchanged. heard__ENA pulsed while outstanding=0 is ignored, so recv_idx does not change.
- Mid-burst reset: nRST low during RUN with 2 says outstanding → next cycle start__RDY=1 and all other outputs at reset values. A new burst then runs cleanly.
